lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the LSU<->memory single-bus protocol (lsu_memory_*/memory_lsu_*).
//  Accepts one load/store op from EX, checks alignment/width, issues a single-cycle request,
//  waits for the memory response, sign/zero-extends load data and hands the result to writeback.
//  Sits in core_top between the EX stage and the memory port; one op in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before a timeout error is reported (>=2)
//  CNT_W           11    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  core_clk          in   1   clock, all state updates on posedge
//  core_rst          in   1   reset, synchronous, active-high
//  ex_lsu_valid      in   1   EX presents an op
//  ex_lsu_ready      out  1   block can accept (state==IDLE)
//  ex_lsu_addr       in   64  byte address
//  ex_lsu_wdata      in   64  store data, right-aligned
//  ex_lsu_dir        in   1   0=load 1=store
//  ex_lsu_width      in   4   bytes: 1,2,4,8 legal
//  ex_lsu_signed     in   1   load sign-extend enable
//  lsu_memory_addr   out  64  request address
//  lsu_memory_data   out  64  store data, bytes above width forced 0
//  lsu_memory_dir    out  1   0=read 1=write
//  lsu_memory_width  out  4   byte count
//  lsu_memory_valid  out  1   request strobe
//  memory_lsu_ready  in   1   memory accepts request this cycle
//  memory_lsu_valid  in   1   response valid (read data / write ack)
//  memory_lsu_data   in   64  read data, right-aligned (low bytes)
//  lsu_wb_valid      out  1   result valid
//  lsu_wb_ready      in   1   writeback accepts result
//  lsu_wb_data       out  64  extended load data; 0 for stores/errors
//  lsu_wb_err        out  2   0 ok, 1 misaligned, 2 bad width, 3 timeout
// BEHAVIOUR
//  Reset: state=IDLE; ex_lsu_ready=1 (after reset); lsu_memory_valid=0, addr/data/dir/width=0;
//   lsu_wb_valid=0, lsu_wb_data=0, lsu_wb_err=0; timeout counter=0. Reset mid-op aborts the
//   op with no further request/response; a memory response arriving later in IDLE is ignored.
//  FSM IDLE->REQ->WAIT->RESP->IDLE; all outputs registered.
//  IDLE: on ex_lsu_valid&ex_lsu_ready latch op. Width not in {1,2,4,8} -> RESP err=2;
//   else addr[log2(width)-1:0]!=0 -> RESP err=1; else -> REQ. Error paths issue no memory request.
//  REQ: lsu_memory_valid=1 with latched fields. valid&memory_lsu_ready at posedge -> WAIT,
//   valid drops next cycle (strictly one accepted strobe per op, so no duplicate store).
//   No ready -> hold all request fields stable, stay in REQ (no timeout in REQ).
//  WAIT: counter increments each cycle; memory_lsu_valid -> RESP, err=0, capture data;
//   counter reaching TIMEOUT_CYCLES-1 without response -> RESP err=3. Response and timeout in same
//   cycle: response wins. memory_lsu_valid outside WAIT is ignored.
//  Load extension (width w, d=memory_lsu_data): signed -> sext(d[8w-1:0]) to 64, else zext;
//   w=8 passes d unchanged. Stores: lsu_wb_data=0.
//  RESP: lsu_wb_valid=1, data/err stable until lsu_wb_ready; on valid&ready -> IDLE next cycle.
//  Latency (ready=1, zero-delay memory): accept T, strobe T+1, response sampled T+2,
//   lsu_wb_valid T+3. Error paths: lsu_wb_valid at T+1.
//  ex_lsu_ready=0 in REQ/WAIT/RESP; no new op accepted until the cycle after wb handshake.
// TESTING
//  1 load: addr=0x8000_0010 w=1 signed=1, mem data=0x80 -> wb_data=0xFFFF_FFFF_FFFF_FF80, err=0, wb at T+3
//  2 store: addr=0x8000_0008 w=4 wdata=0x1122_3344_5566_7788 -> memory_data=0x5566_7788, one strobe, wb_data=0
//  3 misaligned: w=4 addr=0x8000_0002 -> no lsu_memory_valid, wb err=1 at T+1; w=3 -> err=2
//  4 backpressure: memory_lsu_ready low 5 cycles, lsu_wb_ready low 3 -> fields stable, single strobe, single wb
//  5 timeout: TIMEOUT_CYCLES=8, no response -> err=3 after 8 WAIT cycles; late response ignored
//  6 reset asserted in WAIT -> all outputs 0 next cycle, ex_lsu_ready=1, no stray wb_valid

Source files
------------

// File: rtl/lsu_mem_master.sv
// LSU initiator for the single-bus memory protocol: validates one load/store from EX,
// issues one request, waits for the response and returns extended load data to writeback.
module lsu_mem_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        ex_lsu_valid,
    output logic        ex_lsu_ready,
    input  logic [63:0] ex_lsu_addr,
    input  logic [63:0] ex_lsu_wdata,
    input  logic        ex_lsu_dir,
    input  logic [3:0]  ex_lsu_width,
    input  logic        ex_lsu_signed,
    output logic [63:0] lsu_memory_addr,
    output logic [63:0] lsu_memory_data,
    output logic        lsu_memory_dir,
    output logic [3:0]  lsu_memory_width,
    output logic        lsu_memory_valid,
    input  logic        memory_lsu_ready,
    input  logic        memory_lsu_valid,
    input  logic [63:0] memory_lsu_data,
    output logic        lsu_wb_valid,
    input  logic        lsu_wb_ready,
    output logic [63:0] lsu_wb_data,
    output logic [1:0]  lsu_wb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             op_dir;
    logic [3:0]       op_width;
    logic             op_signed;
    logic             width_ok;
    logic             misaligned;

    function automatic logic [63:0] mask_store(input logic [63:0] d, input logic [3:0] w);
        case (w)
            4'd1:    mask_store = {56'b0, d[7:0]};
            4'd2:    mask_store = {48'b0, d[15:0]};
            4'd4:    mask_store = {32'b0, d[31:0]};
            default: mask_store = d;
        endcase
    endfunction

    function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [3:0] w,
                                                input logic s);
        case (w)
            4'd1:    extend_load = {{56{s & d[7]}}, d[7:0]};
            4'd2:    extend_load = {{48{s & d[15]}}, d[15:0]};
            4'd4:    extend_load = {{32{s & d[31]}}, d[31:0]};
            default: extend_load = d;
        endcase
    endfunction

    // Alignment requires the low log2(width) address bits to be zero.
    always_comb begin
        width_ok   = 1'b1;
        misaligned = 1'b0;
        case (ex_lsu_width)
            4'd1:    misaligned = 1'b0;
            4'd2:    misaligned = ex_lsu_addr[0];
            4'd4:    misaligned = |ex_lsu_addr[1:0];
            4'd8:    misaligned = |ex_lsu_addr[2:0];
            default: width_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state            <= S_IDLE;
            wait_cnt         <= '0;
            op_dir           <= 1'b0;
            op_width         <= 4'd0;
            op_signed        <= 1'b0;
            ex_lsu_ready     <= 1'b1;
            lsu_memory_addr  <= 64'd0;
            lsu_memory_data  <= 64'd0;
            lsu_memory_dir   <= 1'b0;
            lsu_memory_width <= 4'd0;
            lsu_memory_valid <= 1'b0;
            lsu_wb_valid     <= 1'b0;
            lsu_wb_data      <= 64'd0;
            lsu_wb_err       <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_lsu_valid && ex_lsu_ready) begin
                        op_dir       <= ex_lsu_dir;
                        op_width     <= ex_lsu_width;
                        op_signed    <= ex_lsu_signed;
                        ex_lsu_ready <= 1'b0;
                        if (!width_ok) begin
                            state        <= S_RESP;
                            lsu_wb_valid <= 1'b1;
                            lsu_wb_data  <= 64'd0;
                            lsu_wb_err   <= 2'd2;
                        end else if (misaligned) begin
                            state        <= S_RESP;
                            lsu_wb_valid <= 1'b1;
                            lsu_wb_data  <= 64'd0;
                            lsu_wb_err   <= 2'd1;
                        end else begin
                            state            <= S_REQ;
                            lsu_memory_valid <= 1'b1;
                            lsu_memory_addr  <= ex_lsu_addr;
                            lsu_memory_data  <= ex_lsu_dir ? mask_store(ex_lsu_wdata, ex_lsu_width)
                                                           : 64'd0;
                            lsu_memory_dir   <= ex_lsu_dir;
                            lsu_memory_width <= ex_lsu_width;
                        end
                    end
                end
                // Fields stay untouched until accepted, so exactly one strobe is seen per op.
                S_REQ: begin
                    if (memory_lsu_ready) begin
                        state            <= S_WAIT;
                        wait_cnt         <= '0;
                        lsu_memory_valid <= 1'b0;
                        lsu_memory_addr  <= 64'd0;
                        lsu_memory_data  <= 64'd0;
                        lsu_memory_dir   <= 1'b0;
                        lsu_memory_width <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (memory_lsu_valid) begin
                        state        <= S_RESP;
                        wait_cnt     <= '0;
                        lsu_wb_valid <= 1'b1;
                        lsu_wb_err   <= 2'd0;
                        lsu_wb_data  <= op_dir ? 64'd0
                                               : extend_load(memory_lsu_data, op_width, op_signed);
                    end else if (wait_cnt == CNT_LAST) begin
                        state        <= S_RESP;
                        wait_cnt     <= '0;
                        lsu_wb_valid <= 1'b1;
                        lsu_wb_err   <= 2'd3;
                        lsu_wb_data  <= 64'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (lsu_wb_ready) begin
                        state        <= S_IDLE;
                        ex_lsu_ready <= 1'b1;
                        lsu_wb_valid <= 1'b0;
                        lsu_wb_data  <= 64'd0;
                        lsu_wb_err   <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
